// File: rtl/filter_switch_ctrl.sv
// -----------------------------------------------------------------------------
// filter_switch_ctrl
//
// Applies the key-driven filter selection to a pixel stream only at frame
// boundaries, so that a single frame is never processed by two filters.
// The stream passes through one backpressure-aware register stage. Every
// pixel leaving that stage is tagged with the filter that must process it.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   filter_type[1:0]    requested filter (00 COLOUR, 01 BLUR, 10 BRIGHTNESS,
//                       11 EDGES)
//   in_data/in_valid/in_sop/in_eop, in_ready      upstream pixel stream
//   out_data/out_valid/out_sop/out_eop/out_filter, out_ready
//                                                 downstream pixel stream
//   active_filter[1:0]  filter currently committed
//   filter_changed      one-cycle pulse after a commit
//   switch_timeout      one-cycle pulse after a commit forced by timeout
//
// Optional build macro:
//   SETTLE_BLANK_EN     when defined, pixels accepted while settling after a
//                       switch are loaded with zero data, masking filter
//                       warm-up artefacts. sop/eop/valid/tag are unaffected.
// -----------------------------------------------------------------------------
module filter_switch_ctrl #(
  parameter int DATA_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int SETTLE_FRAMES  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            filter_type,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [1:0]            out_filter,
  input  logic                  out_ready,
  output logic [1:0]            active_filter,
  output logic                  filter_changed,
  output logic                  switch_timeout
);

  // Counter widths. Both are at least one bit so that degenerate parameter
  // values (TIMEOUT_CYCLES = 1, SETTLE_FRAMES = 0) still elaborate.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'((SETTLE_FRAMES > 0) ? (SETTLE_FRAMES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timeout_cnt_reg, timeout_cnt_next;
  logic [SW-1:0]   settle_cnt_reg, settle_cnt_next;

  logic            in_fire;
  logic            eop_fire;
  logic            commit;
  logic            commit_timeout;
  logic [DATA_WIDTH-1:0] load_data;

  // ---------------------------------------------------------------------------
  // Stream handshakes
  // ---------------------------------------------------------------------------
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign eop_fire = in_fire && in_eop;

`ifdef SETTLE_BLANK_EN
  // Blanking is applied when the pixel is loaded, not on the output, so a
  // stalled pixel keeps its value even if the FSM leaves SETTLE meanwhile.
  assign load_data = (state_reg == SETTLE) ? '0 : in_data;
`else
  assign load_data = in_data;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      timeout_cnt_reg <= '0;
      settle_cnt_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      timeout_cnt_reg <= timeout_cnt_next;
      settle_cnt_reg  <= settle_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    timeout_cnt_next = timeout_cnt_reg;
    settle_cnt_next  = settle_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (filter_type != active_filter) begin
          state_next       = PENDING;
          timeout_cnt_next = '0;
        end
      end
      PENDING: begin
        // The pending request is filter_type itself: it tracks the input
        // every cycle, and a commit takes whatever is sampled on that edge.
        if (filter_type == active_filter) begin
          state_next = IDLE;
        end else if (commit) begin
          state_next      = SETTLE;
          settle_cnt_next = '0;
        end else if (timeout_cnt_reg != TIMEOUT_LAST) begin
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
        end
      end
      SETTLE: begin
        if (SETTLE_FRAMES == 0) begin
          state_next = IDLE;
        end else if (eop_fire) begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next      = IDLE;
            settle_cnt_next = '0;
          end else begin
            settle_cnt_next = settle_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // An end-of-frame takes priority over the timeout threshold, so a commit
  // that coincides with both is reported as a normal frame-boundary commit.
  // ---------------------------------------------------------------------------
  always_comb begin
    commit         = 1'b0;
    commit_timeout = 1'b0;
    case (state_reg)
      PENDING: begin
        if (filter_type != active_filter) begin
          if (eop_fire) begin
            commit = 1'b1;
          end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
            commit         = 1'b1;
            commit_timeout = 1'b1;
          end
        end
      end
      default: begin
        commit         = 1'b0;
        commit_timeout = 1'b0;
      end
    endcase
  end

  // Committed filter and the status pulses. The pulses appear in the cycle
  // after the commit edge, together with the new active_filter value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_filter  <= 2'b00;
      filter_changed <= 1'b0;
      switch_timeout <= 1'b0;
    end else begin
      if (commit) begin
        active_filter <= filter_type;
      end
      filter_changed <= commit;
      switch_timeout <= commit_timeout;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage. The tag is the committed filter before this edge,
  // so the eop that triggers a commit still carries the old filter and the
  // next frame's first pixel carries the new one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_filter <= 2'b00;
    end else begin
      if (in_fire) begin
        out_valid  <= 1'b1;
        out_data   <= load_data;
        out_sop    <= in_sop;
        out_eop    <= in_eop;
        out_filter <= active_filter;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_filter_switch_ctrl.sv
module tb_filter_switch_ctrl;

  localparam int DW = 12;
  localparam int TO = 50;
  localparam int SF = 1;
`ifdef SETTLE_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [1:0]    filter_type;
  logic [DW-1:0] in_data;
  logic          in_valid, in_sop, in_eop, in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop;
  logic [1:0]    out_filter;
  logic          out_ready;
  logic [1:0]    active_filter;
  logic          filter_changed, switch_timeout;

  filter_switch_ctrl #(
    .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .SETTLE_FRAMES(SF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .filter_type(filter_type),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_filter(out_filter),
    .out_ready(out_ready), .active_filter(active_filter),
    .filter_changed(filter_changed), .switch_timeout(switch_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected output register contents plus the switching
  // rules expressed as "idle / waiting for a boundary / settling" phases.
  bit            m_valid;
  logic [DW-1:0] m_data;
  logic          m_sop, m_eop;
  logic [1:0]    m_tag, m_active;
  bit            m_chg, m_to;
  int            phase;      // 0 idle, 1 waiting, 2 settling
  int            waited;     // cycles spent waiting so far
  int            frames;     // frame ends seen while settling
  logic [DW-1:0] sb[$];      // pixels accepted, not yet delivered
  bit            last_acc;
  int            chg_count;

  typedef struct {
    logic [1:0] ft; logic v; logic [DW-1:0] d; logic s; logic e; logic r;
    logic ev; logic [DW-1:0] ed; logic eblank; logic [1:0] etag;
    logic [1:0] eact; logic echg;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_sop = 0; m_eop = 0; m_tag = 2'd0;
    m_active = 2'd0; m_chg = 0; m_to = 0;
    phase = 0; waited = 0; frames = 0;
    sb.delete();
  endtask

  task automatic model_edge(input logic [1:0] ft, input logic v,
                            input logic [DW-1:0] d, input logic s,
                            input logic e, input logic r, output bit acc);
    bit eopf;
    acc  = v && (!m_valid || r);
    eopf = acc && e;
    m_chg = 0; m_to = 0;
    if (acc) begin
      m_valid = 1;
      m_data  = (BLANK && phase == 2) ? '0 : d;
      m_sop = s; m_eop = e; m_tag = m_active;
    end else if (r) begin
      m_valid = 0;
    end
    case (phase)
      0: if (ft != m_active) begin phase = 1; waited = 0; end
      1: begin
        if (ft == m_active) phase = 0;
        else if (eopf) begin
          m_active = ft; m_chg = 1; phase = 2; frames = 0;
        end else begin
          waited++;
          if (waited == TO) begin
            m_active = ft; m_chg = 1; m_to = 1; phase = 2; frames = 0;
          end
        end
      end
      default: begin
        if (SF == 0) phase = 0;
        else if (eopf) begin
          frames++;
          if (frames >= SF) phase = 0;
        end
      end
    endcase
  endtask

  // One clock cycle: drive, check pre-edge signals, advance, check outputs.
  task automatic cyc(input logic [1:0] ft, input logic v, input logic [DW-1:0] d,
                     input logic s, input logic e, input logic r);
    bit acc;
    filter_type = ft; in_valid = v; in_data = d; in_sop = s; in_eop = e;
    out_ready = r;
    #1;
    chk("in_ready", in_ready, (!m_valid || r) ? 1 : 0);
    if (out_valid && r) begin
      chk("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
      if (sb.size() != 0) chk("sb_data", out_data, sb.pop_front());
    end
    model_edge(ft, v, d, s, e, r, acc);
    if (acc) sb.push_back(m_data);
    last_acc = acc;
    @(posedge clk); #1;
    if (filter_changed) chg_count++;
    chk("out_valid", out_valid, m_valid);
    chk("active_filter", active_filter, m_active);
    chk("filter_changed", filter_changed, m_chg);
    chk("switch_timeout", switch_timeout, m_to);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_sop", out_sop, m_sop);
      chk("out_eop", out_eop, m_eop);
      chk("out_filter", out_filter, m_tag);
    end
  endtask

  // Sends an n-pixel frame; filter_type switches from ft0 to ft1 at pixel
  // chg_at. With bp set, out_ready alternates 1,0,1,0...
  task automatic send_frame(input int n, input logic [1:0] ft0, input int chg_at,
                            input logic [1:0] ft1, input bit bp,
                            input logic [DW-1:0] base);
    int i; int guard; bit rt; logic [1:0] ft; logic [DW-1:0] d;
    i = 0; guard = 0; rt = 1;
    while (i < n && guard < 8 * n) begin
      ft = (i >= chg_at) ? ft1 : ft0;
      d  = base + DW'(i);
      cyc(ft, 1'b1, d, (i == 0), (i == n - 1), bp ? rt : 1'b1);
      rt = !rt;
      if (last_acc) i++;
      guard++;
    end
    chk("frame_done", i, n);
  endtask

  task automatic do_reset(input int n);
    rst_n = 0; in_valid = 0; in_sop = 0; in_eop = 0; out_ready = 1;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    chk("rst_active", active_filter, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_changed", filter_changed, 0);
    chk("rst_timeout", switch_timeout, 0);
  endtask

  initial begin
    int found; int n; int i; int guard; int gap;
    logic [1:0] rft; logic rv; logic rr; logic [DW-1:0] rd;

    vecs[0] = '{2'd0, 1'b1, 12'h101, 1'b1, 1'b0, 1'b1, 1'b1, 12'h101, 1'b0, 2'd0, 2'd0, 1'b0};
    vecs[1] = '{2'd3, 1'b1, 12'h102, 1'b0, 1'b0, 1'b1, 1'b1, 12'h102, 1'b0, 2'd0, 2'd0, 1'b0};
    vecs[2] = '{2'd3, 1'b1, 12'h103, 1'b0, 1'b0, 1'b1, 1'b1, 12'h103, 1'b0, 2'd0, 2'd0, 1'b0};
    vecs[3] = '{2'd3, 1'b1, 12'h104, 1'b0, 1'b1, 1'b1, 1'b1, 12'h104, 1'b0, 2'd0, 2'd3, 1'b1};
    vecs[4] = '{2'd3, 1'b1, 12'h201, 1'b1, 1'b0, 1'b1, 1'b1, 12'h201, 1'b1, 2'd3, 2'd3, 1'b0};
    vecs[5] = '{2'd3, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 2'd3, 2'd3, 1'b0};
    vecs[6] = '{2'd3, 1'b1, 12'h202, 1'b0, 1'b1, 1'b1, 1'b1, 12'h202, 1'b1, 2'd3, 2'd3, 1'b0};
    vecs[7] = '{2'd3, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h202, 1'b1, 2'd3, 2'd3, 1'b0};
    vecs[8] = '{2'd3, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 2'd3, 2'd3, 1'b0};

    filter_type = 2'd0; in_data = '0; chg_count = 0; last_acc = 0;
    do_reset(3);

    // Plain 4x4 frame, all pixels tagged COLOUR.
    send_frame(16, 2'd0, 99, 2'd0, 1'b0, 12'h010);
    cyc(2'd0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Table: mid-frame request committed on the eop edge.
    for (int k = 0; k < 9; k++) begin
      cyc(vecs[k].ft, vecs[k].v, vecs[k].d, vecs[k].s, vecs[k].e, vecs[k].r);
      chk("tbl_valid", out_valid, vecs[k].ev);
      if (vecs[k].ev) begin
        chk("tbl_data", out_data, (BLANK && vecs[k].eblank) ? 0 : vecs[k].ed);
        chk("tbl_tag", out_filter, vecs[k].etag);
      end
      chk("tbl_active", active_filter, vecs[k].eact);
      chk("tbl_changed", filter_changed, vecs[k].echg);
    end

    // Request bounce within one frame: no commit.
    chg_count = 0;
    cyc(2'd3, 1'b1, 12'h301, 1'b1, 1'b0, 1'b1);
    cyc(2'd0, 1'b1, 12'h302, 1'b0, 1'b0, 1'b1);
    cyc(2'd3, 1'b1, 12'h303, 1'b0, 1'b0, 1'b1);
    cyc(2'd3, 1'b1, 12'h304, 1'b0, 1'b1, 1'b1);
    cyc(2'd3, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("bounce_active", active_filter, 3);
    chk("bounce_pulses", chg_count, 0);

    // Timeout: no frame traffic after a request for BRIGHTNESS.
    found = -1;
    for (int k = 0; k < 200; k++) begin
      cyc(2'd2, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (filter_changed) begin
        found = k;
        chk("timeout_pulse", switch_timeout, 1);
        chk("timeout_active", active_filter, 2);
        break;
      end
    end
    chk("timeout_cycle", found, TO);
    send_frame(4, 2'd2, 99, 2'd2, 1'b0, 12'h400);

    // Settle: 01 committed at frame X; 10 requested during Y is ignored
    // until Y ends, then committed at the end of Z.
    send_frame(6, 2'd2, 2, 2'd1, 1'b0, 12'h500);
    chk("settle_x_active", active_filter, 1);
    send_frame(6, 2'd1, 2, 2'd2, 1'b0, 12'h600);
    chk("settle_y_active", active_filter, 1);
    send_frame(6, 2'd2, 0, 2'd2, 1'b0, 12'h700);
    chk("settle_z_active", active_filter, 2);

    // Backpressure with out_ready alternating across a frame.
    send_frame(16, 2'd2, 99, 2'd2, 1'b1, 12'h800);

    // Randomized frames, gaps, requests and backpressure.
    rft = 2'd2;
    for (int f = 0; f < 150; f++) begin
      n = $urandom_range(2, 8); i = 0; guard = 0;
      while (i < n && guard < 100) begin
        rv = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 3) != 0);
        rd = DW'($urandom);
        if ($urandom_range(0, 15) == 0) rft = 2'($urandom_range(0, 3));
        cyc(rft, rv, rd, rv && (i == 0), rv && (i == n - 1), rr);
        if (last_acc) i++;
        guard++;
      end
      if ($urandom_range(0, 9) == 0) begin
        gap = $urandom_range(0, 60);
        for (int g = 0; g < gap; g++) cyc(rft, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      end
    end

    // Drain and confirm every accepted pixel came out exactly once.
    cyc(rft, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(rft, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("sb_empty", sb.size(), 0);

    // Reset with a stalled pixel held and a request pending.
    cyc(2'd1, 1'b1, 12'h9AB, 1'b1, 1'b0, 1'b0);
    cyc(2'd3, 1'b1, 12'h9AC, 1'b0, 1'b0, 1'b0);
    do_reset(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
